parkimetro_io: RTL and testbench



---
 rtl/parkimetro_pkg.sv | 18 +
 rtl/parkimetro_io_sensor_debounce.sv | 46 ++++
 rtl/parkimetro_io.sv | 147 ++++++++++++++
 tb/tb_parkimetro_io.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/parkimetro_pkg.sv
// Shared sensor codes and FSM state encoding for the parking-meter sensor front-end.
package parkimetro_pkg;

  // Filtered sensor codes, packed as {a, b}
  localparam logic [1:0] VACIO       = 2'b00;
  localparam logic [1:0] MOVIENDOSE  = 2'b10;
  localparam logic [1:0] ESTACIONADO = 2'b11;
  localparam logic [1:0] INVALIDO    = 2'b01;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRANDO = 3'd1,
    PARKED   = 3'd2,
    SALIENDO = 3'd3,
    ERR      = 3'd4
  } state_e;

endpackage

// File: rtl/parkimetro_io_sensor_debounce.sv
// Two-flop synchroniser plus stability counter for one light-barrier input.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts consecutive cycles in which the synced value disagrees with filt_q
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/parkimetro_io.sv
// Parking-meter sensor front-end: debounced {a,b} tracked by a vehicle FSM emitting entra/sale/error pulses.
// Optional saturating event counters are enabled with `define PARKIMETRO_EVENT_COUNT_EN.
module parkimetro_io
  import parkimetro_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             entra,
  output logic             sale,
  output logic             error
`ifdef PARKIMETRO_EVENT_COUNT_EN
  ,
  output logic [CNT_W-1:0] count_entra,
  output logic [CNT_W-1:0] count_sale,
  output logic [CNT_W-1:0] count_error
`endif
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..32");
  end

  logic [1:0] filt_ab;
  logic [1:0] filt_prev_q;
  state_e     state_q, state_d;
  logic       entra_q, entra_d;
  logic       sale_q, sale_d;
  logic       error_q, error_d;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (reset),
    .raw_i (a),
    .filt_o(filt_ab[1])
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst_n (reset),
    .raw_i (b),
    .filt_o(filt_ab[0])
  );

  // The FSM only moves when the filtered code differs from last cycle's
  always_comb begin
    state_d = state_q;
    entra_d = 1'b0;
    sale_d  = 1'b0;
    error_d = 1'b0;
    if (filt_ab != filt_prev_q) begin
      case (state_q)
        IDLE: begin
          if (filt_ab == MOVIENDOSE) begin
            state_d = ENTRANDO;
          end else if (filt_ab == ESTACIONADO || filt_ab == INVALIDO) begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
        ENTRANDO: begin
          if (filt_ab == ESTACIONADO) begin
            state_d = PARKED;
            entra_d = 1'b1;
          end else if (filt_ab == VACIO) begin
            state_d = IDLE;
          end else if (filt_ab == INVALIDO) begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
        PARKED: begin
          if (filt_ab == MOVIENDOSE) begin
            state_d = SALIENDO;
          end else if (filt_ab == VACIO || filt_ab == INVALIDO) begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
        SALIENDO: begin
          if (filt_ab == VACIO) begin
            state_d = IDLE;
            sale_d  = 1'b1;
          end else if (filt_ab == ESTACIONADO) begin
            state_d = PARKED;
          end else if (filt_ab == INVALIDO) begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
        ERR: begin
          if (filt_ab == VACIO) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      filt_prev_q <= VACIO;
      entra_q     <= 1'b0;
      sale_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_prev_q <= filt_ab;
      entra_q     <= entra_d;
      sale_q      <= sale_d;
      error_q     <= error_d;
    end
  end

  assign entra = entra_q;
  assign sale  = sale_q;
  assign error = error_q;

`ifdef PARKIMETRO_EVENT_COUNT_EN
  logic [CNT_W-1:0] cnt_entra_q, cnt_sale_q, cnt_error_q;

  // Counters follow the registered pulses and stick at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_entra_q <= '0;
      cnt_sale_q  <= '0;
      cnt_error_q <= '0;
    end else begin
      if (entra_q && cnt_entra_q != '1) cnt_entra_q <= cnt_entra_q + CNT_W'(1);
      if (sale_q  && cnt_sale_q  != '1) cnt_sale_q  <= cnt_sale_q  + CNT_W'(1);
      if (error_q && cnt_error_q != '1) cnt_error_q <= cnt_error_q + CNT_W'(1);
    end
  end

  assign count_entra = cnt_entra_q;
  assign count_sale  = cnt_sale_q;
  assign count_error = cnt_error_q;
`endif

endmodule

// File: tb/tb_parkimetro_io.sv
// Scoreboard bench for parkimetro_io: stimulus queues expected pulses, a negedge monitor pops and compares.
module tb_parkimetro_io;

  localparam int LAT = 6;
  localparam int K_ENTRA = 0;
  localparam int K_SALE  = 1;
  localparam int K_ERROR = 2;

  logic clk = 1'b0;
  logic reset;
  logic a, b;
  logic entra, sale, error;
`ifdef PARKIMETRO_EVENT_COUNT_EN
  logic [7:0] count_entra, count_sale, count_error;
`endif

  parkimetro_io #(.DEBOUNCE_CYCLES(3), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .entra      (entra),
    .sale       (sale),
    .error      (error)
`ifdef PARKIMETRO_EVENT_COUNT_EN
    ,
    .count_entra(count_entra),
    .count_sale (count_sale),
    .count_error(count_error)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: every observed pulse must match the oldest expected one
  always @(negedge clk) begin
    int n;
    int kind_seen;
    exp_t e;
    n = int'(entra) + int'(sale) + int'(error);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL exclusive: entra=%0b sale=%0b error=%0b at cycle %0d, required at most one", entra, sale, error, cyc);
    end else if (n == 1) begin
      kind_seen = entra ? K_ENTRA : (sale ? K_SALE : K_ERROR);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", kind_seen, cyc);
      end else begin
        e = q.pop_front();
        if (kind_seen != e.kind) begin
          errors++;
          $display("FAIL pulse_kind: got kind %0d at cycle %0d, required kind %0d", kind_seen, cyc, e.kind);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse_cycle: kind %0d at cycle %0d, required cycle %0d", kind_seen, cyc, e.cyc);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] ab, input int hold, input int kind);
    exp_t e;
    @(negedge clk);
    {a, b} = ab;
    if (kind >= 0) begin
      e.kind = kind;
      e.cyc  = cyc + LAT;
      q.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({entra, sale, error} != 3'b000) begin
      errors++;
      $display("FAIL %s: outputs %b, required 000", name, {entra, sale, error});
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    a = 1'b0;
    b = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    @(negedge clk);
    reset = 1'b1;

    // Aborted entry: no pulse
    drive(2'b00, 5, -1);
    drive(2'b10, 7, -1);
    drive(2'b00, 10, -1);

    // Diagonal 00->11 from IDLE is an error, then recover
    drive(2'b11, 4, K_ERROR);
    drive(2'b00, 10, -1);

    // Entry, aborted exit, real exit
    drive(2'b10, 9, -1);
    drive(2'b11, 10, K_ENTRA);
    drive(2'b10, 10, -1);
    drive(2'b11, 10, -1);
    drive(2'b10, 10, -1);
    drive(2'b00, 10, K_SALE);

`ifdef PARKIMETRO_EVENT_COUNT_EN
    check_val("count_entra_a", int'(count_entra), 1);
    check_val("count_sale_a", int'(count_sale), 1);
    check_val("count_error_a", int'(count_error), 1);
`endif

    // Two-cycle glitch on a is filtered out
    drive(2'b10, 2, -1);
    drive(2'b00, 10, -1);

    // Park, then an illegal 01 for 10 cycles, then clear
    drive(2'b10, 10, -1);
    drive(2'b11, 10, K_ENTRA);
    drive(2'b01, 10, K_ERROR);
    drive(2'b00, 10, -1);

    // Reset while entering drops the pending entra pulse
    drive(2'b10, 10, -1);
    drive(2'b11, 5, -1);
    @(negedge clk);
    reset = 1'b0;
    {a, b} = 2'b00;
    #1;
    check_zero("async_reset_outputs");
    repeat (3) @(negedge clk);
    check_zero("held_reset_outputs");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    drive(2'b11, 10, K_ERROR);
    drive(2'b00, 10, -1);

`ifdef PARKIMETRO_EVENT_COUNT_EN
    check_val("count_entra_b", int'(count_entra), 0);
    check_val("count_sale_b", int'(count_sale), 0);
    check_val("count_error_b", int'(count_error), 1);
`endif

    repeat (10) @(negedge clk);
    check_val("pending_expected", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
